// File: rtl/pim_buf_pkg.sv
// Shared types and constants for the banked PIM operand stream buffer.
package pim_buf_pkg;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned DEF_NUM_BANKS = 4;
  localparam int unsigned BANK_SEL_W    = $clog2(DEF_NUM_BANKS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} strm_state_e;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;
endpackage

// File: rtl/pim_buffer_bank.sv
// Single-port byte-strobed RAM bank with a registered read (read returns pre-write data).
module pim_buffer_bank
  import pim_buf_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1792,
  parameter int unsigned ROW_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [ROW_W-1:0]      addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < int'(WORD_BYTES); b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/pim_stream_buffer.sv
// Word-interleaved PIM operand buffer: CPU word port plus a burst stream engine
// feeding a 2-entry skid FIFO; the CPU always wins a bank conflict.
module pim_stream_buffer
  import pim_buf_pkg::*;
#(
  parameter int unsigned MEM_DEPTH       = 28672,
  parameter int unsigned MEM_ADDR_WIDTH  = 15,
  parameter int unsigned NUM_BANKS       = DEF_NUM_BANKS,
  parameter int unsigned BURST_LEN_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [31:0]                i_buf_addr,
  input  logic [31:0]                i_buf_wr_data,
  input  logic [3:0]                 i_buf_size,
  input  logic                       i_buf_write,
  input  logic                       i_buf_read,
  output logic [31:0]                o_buf_rd_data,
  output logic                       o_buf_rd_valid,
  input  logic                       i_strm_start,
  input  logic [MEM_ADDR_WIDTH-1:0]  i_strm_base,
  input  logic [BURST_LEN_WIDTH-1:0] i_strm_len,
  output logic                       o_strm_busy,
  output logic [31:0]                o_strm_data,
  output logic                       o_strm_valid,
  input  logic                       i_strm_ready,
  output logic                       o_strm_last,
  output logic                       o_strm_done
);

  localparam int unsigned AW     = MEM_ADDR_WIDTH;
  localparam int unsigned BL     = BURST_LEN_WIDTH;
  localparam int unsigned WA_W   = AW - 2;
  localparam int unsigned WORDS  = MEM_DEPTH / WORD_BYTES;
  localparam int unsigned ROWS   = WORDS / NUM_BANKS;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned BANK_W = (NUM_BANKS == DEF_NUM_BANKS) ? BANK_SEL_W : $clog2(NUM_BANKS);

  strm_state_e state_q, state_d;

  logic [WA_W-1:0]   ptr_q, ptr_nxt;
  logic [BL-1:0]     len_q, issue_cnt_q;
  logic              rd_pend_q, rd_last_q;
  logic [BANK_W-1:0] rd_bank_q, cpu_bank_q;
  logic [1:0]        cnt_q;
  beat_t             head_q, tail_q, push_beat;
  logic [31:0]       rd_hold_q;
  logic [31:0]       bank_rdata [NUM_BANKS];

  logic              cpu_req, bank_clash, room, pop, push, issue_last;
  logic              issue_c, start_c;
  logic [WA_W-1:0]   cpu_word;
  logic [BANK_W-1:0] cpu_bank, strm_bank;
  logic [ROW_W-1:0]  cpu_row, strm_row;

  logic unused_bits;
  assign unused_bits = ^{i_buf_addr[31:AW], i_buf_addr[1:0], i_strm_base[1:0]};

  // Address decode: low word bits pick the bank, the rest pick the row.
  assign cpu_word  = i_buf_addr[AW-1:2];
  assign cpu_bank  = cpu_word[BANK_W-1:0];
  assign cpu_row   = ROW_W'(cpu_word >> BANK_W);
  assign strm_bank = ptr_q[BANK_W-1:0];
  assign strm_row  = ROW_W'(ptr_q >> BANK_W);

  assign cpu_req    = i_buf_read || i_buf_write;
  assign bank_clash = cpu_req && (cpu_bank == strm_bank);
  assign pop        = o_strm_valid && i_strm_ready;
  assign push       = rd_pend_q;
  // A slot freed by this cycle's pop can be refilled by a read issued now.
  assign room       = ({1'b0, cnt_q} + 3'(rd_pend_q)) <= (3'd1 + 3'(pop));
  assign issue_last = (issue_cnt_q == (len_q - BL'(1)));
  assign ptr_nxt    = ((32'(ptr_q) + 32'd1) >= WORDS) ? '0 : ptr_q + WA_W'(1);

  for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
    logic cpu_hit, strm_hit;
    assign cpu_hit  = cpu_req && (cpu_bank == BANK_W'(b));
    assign strm_hit = issue_c && (strm_bank == BANK_W'(b));

    pim_buffer_bank #(.DEPTH_WORDS(ROWS), .ROW_W(ROW_W)) u_bank (
      .clk   (i_clk),
      .en    (cpu_hit || strm_hit),
      .we    ((cpu_hit && i_buf_write) ? i_buf_size : 4'b0),
      .addr  (cpu_hit ? cpu_row : strm_row),
      .wdata (i_buf_wr_data),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Stream FSM: next state and per-cycle issue/start strobes.
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    start_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_c = i_strm_start;
        if (i_strm_start) state_d = (i_strm_len == '0) ? DONE : RUN;
      end
      RUN: begin
        issue_c = !bank_clash && room;
        if (issue_c && issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (!rd_pend_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop))) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign push_beat.last = rd_last_q;
  assign push_beat.data = bank_rdata[rd_bank_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_bank_q   <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      if (start_c) begin
        ptr_q       <= i_strm_base[AW-1:2];
        len_q       <= i_strm_len;
        issue_cnt_q <= '0;
      end else if (issue_c) begin
        ptr_q       <= ptr_nxt;
        issue_cnt_q <= issue_cnt_q + BL'(1);
      end
      rd_pend_q <= issue_c;
      rd_last_q <= issue_last;
      rd_bank_q <= strm_bank;
      // Skid FIFO: head_q always drives the output so it is stable while stalled.
      if (pop) begin
        if (cnt_q == 2'd2)  head_q <= tail_q;
        else if (push)      head_q <= push_beat;
        if ((cnt_q == 2'd2) && push) tail_q <= push_beat;
      end else if (push) begin
        if (cnt_q == 2'd0) head_q <= push_beat;
        else               tail_q <= push_beat;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_buf_rd_valid <= 1'b0;
      cpu_bank_q     <= '0;
      rd_hold_q      <= '0;
    end else begin
      o_buf_rd_valid <= i_buf_read;
      if (i_buf_read)     cpu_bank_q <= cpu_bank;
      if (o_buf_rd_valid) rd_hold_q  <= bank_rdata[cpu_bank_q];
    end
  end

  assign o_buf_rd_data = o_buf_rd_valid ? bank_rdata[cpu_bank_q] : rd_hold_q;
  assign o_strm_valid  = (cnt_q != 2'd0);
  assign o_strm_data   = head_q.data;
  assign o_strm_last   = o_strm_valid && head_q.last;
  assign o_strm_busy   = (state_q != IDLE);
  assign o_strm_done   = (state_q == DONE);

endmodule

// File: tb/tb_pim_stream_buffer.sv
// Directed bench for pim_stream_buffer with a queue/array reference model checked every cycle.
module tb_pim_stream_buffer;
  localparam int unsigned MEM_DEPTH = 28672;
  localparam int unsigned AW        = 15;
  localparam int unsigned BL        = 8;
  localparam int unsigned NWORDS    = MEM_DEPTH / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   i_buf_addr = '0;
  logic [31:0]   i_buf_wr_data = '0;
  logic [3:0]    i_buf_size = '0;
  logic          i_buf_write = 1'b0;
  logic          i_buf_read = 1'b0;
  logic [31:0]   o_buf_rd_data;
  logic          o_buf_rd_valid;
  logic          i_strm_start = 1'b0;
  logic [AW-1:0] i_strm_base = '0;
  logic [BL-1:0] i_strm_len = '0;
  logic          o_strm_busy;
  logic [31:0]   o_strm_data;
  logic          o_strm_valid;
  logic          i_strm_ready = 1'b1;
  logic          o_strm_last;
  logic          o_strm_done;

  always #5 clk = ~clk;

  pim_stream_buffer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_buf_addr(i_buf_addr), .i_buf_wr_data(i_buf_wr_data), .i_buf_size(i_buf_size),
    .i_buf_write(i_buf_write), .i_buf_read(i_buf_read),
    .o_buf_rd_data(o_buf_rd_data), .o_buf_rd_valid(o_buf_rd_valid),
    .i_strm_start(i_strm_start), .i_strm_base(i_strm_base), .i_strm_len(i_strm_len),
    .o_strm_busy(o_strm_busy), .o_strm_data(o_strm_data), .o_strm_valid(o_strm_valid),
    .i_strm_ready(i_strm_ready), .o_strm_last(o_strm_last), .o_strm_done(o_strm_done)
  );

  typedef struct packed {logic [31:0] d; logic l;} beat_s;

  logic [31:0] mem_m [8192];
  beat_s       exp_q[$];
  logic [31:0] got_q[$];
  bit          m_busy, m_done, rd_pend_m;
  logic [31:0] rd_exp, rd_hold_m;
  int          n_pass = 0, n_total = 0, done_cnt = 0, cyc = 0;
  int          first_hs = -1, last_hs = -1;
  bit          rdy_pat [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: stream = words base/4 + i modulo buffer size; CPU reads see pre-write data.
  always @(negedge clk) begin : model
    bit    nd;
    beat_s b;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_busy = 0; m_done = 0; rd_pend_m = 0; rd_hold_m = '0;
    end else begin
      chk("busy", 32'(o_strm_busy), 32'(m_busy));
      chk("done", 32'(o_strm_done), 32'(m_done));
      if (o_strm_done) done_cnt++;
      chk("rd_valid", 32'(o_buf_rd_valid), 32'(rd_pend_m));
      chk(rd_pend_m ? "rd_data" : "rd_hold", o_buf_rd_data, rd_pend_m ? rd_exp : rd_hold_m);
      nd = 0;
      if (o_strm_valid) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'(o_strm_valid), 32'd0);
        else begin
          chk("strm_data", o_strm_data, exp_q[0].d);
          chk("strm_last", 32'(o_strm_last), 32'(exp_q[0].l));
          if (i_strm_ready) begin
            if (exp_q[0].l) nd = 1;
            got_q.push_back(o_strm_data);
            void'(exp_q.pop_front());
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
          end
        end
      end else begin
        chk("last_idle", 32'(o_strm_last), 32'd0);
      end
      if (!m_busy && i_strm_start) begin
        m_busy = 1;
        if (i_strm_len == '0) nd = 1;
        for (int i = 0; i < int'(i_strm_len); i++) begin
          b.d = mem_m[(int'(i_strm_base[AW-1:2]) + i) % NWORDS];
          b.l = (i == int'(i_strm_len) - 1);
          exp_q.push_back(b);
        end
      end else if (m_done) begin
        m_busy = 0;
      end
      m_done = nd;
      if (rd_pend_m) rd_hold_m = rd_exp;
      rd_pend_m = i_buf_read;
      if (i_buf_read) rd_exp = mem_m[i_buf_addr[AW-1:2]];
      if (i_buf_write)
        for (int k = 0; k < 4; k++)
          if (i_buf_size[k]) mem_m[i_buf_addr[AW-1:2]][8*k +: 8] = i_buf_wr_data[8*k +: 8];
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    i_buf_write = 1; i_buf_read = 0; i_buf_addr = a; i_buf_wr_data = d; i_buf_size = s;
  endtask

  task automatic cpu_idle();
    @(posedge clk); #1;
    i_buf_write = 0; i_buf_read = 0;
  endtask

  task automatic cpu_read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    i_buf_write = 0; i_buf_read = 1; i_buf_addr = a;
    @(posedge clk); #1;
    i_buf_read = 0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(o_buf_rd_valid), 32'd1);
    chk(name, o_buf_rd_data, exp);
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) cpu_write(32'(4 * i), 32'(i), 4'hF);
    cpu_idle();
  endtask

  task automatic start_burst(input logic [AW-1:0] base, input logic [BL-1:0] len);
    got_q.delete();
    first_hs = -1;
    @(posedge clk); #1;
    i_strm_start = 1; i_strm_base = base; i_strm_len = len;
    @(posedge clk); #1;
    i_strm_start = 0;
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0,1; mode 2: ready high plus a CPU read every cycle.
  task automatic run_to_idle(input int mode);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (!o_strm_busy) break;
      i_strm_ready = (mode == 1) ? rdy_pat[k % 4] : 1'b1;
      if (mode == 2) begin
        i_buf_read = 1;
        i_buf_addr = ((k % 4) == 3) ? 32'(8 + 16 * (k % 8)) : 32'(4 + 16 * (k % 8));
      end
    end
    i_buf_read = 0; i_strm_ready = 1;
    @(negedge clk);
    chk("idle_timeout", 32'(o_strm_busy), 32'd0);
  endtask

  initial begin
    int d0;
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_strm_busy), 32'd0);
    chk("rst_valid", 32'(o_strm_valid), 32'd0);
    chk("rst_done", 32'(o_strm_done), 32'd0);
    chk("rst_rd_valid", 32'(o_buf_rd_valid), 32'd0);
    chk("rst_rd_data", o_buf_rd_data, 32'd0);
    #2 rst_n = 1;

    // CPU write/read and byte strobe
    cpu_write(32'h10, 32'hDEADBEEF, 4'hF);
    cpu_read_check(32'h10, 32'hDEADBEEF, "t1_rd_full");
    cpu_write(32'h10, 32'h000000AA, 4'h1);
    cpu_read_check(32'h10, 32'hDEADBEAA, "t1_rd_strobe");
    cpu_write(32'h10, 32'h12345678, 4'h0);
    cpu_read_check(32'h10, 32'hDEADBEAA, "t1_rd_nostrobe");

    // Full-rate burst
    preload(32);
    d0 = done_cnt;
    start_burst('0, 8'd16);
    run_to_idle(0);
    chk("t2_beats", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) begin
      chk("t2_beat0", got_q[0], 32'd0);
      chk("t2_beat15", got_q[15], 32'd15);
    end
    chk("t2_rate", 32'(last_hs - first_hs), 32'd15);
    chk("t2_done", 32'(done_cnt - d0), 32'd1);

    // Back-pressure
    start_burst('0, 8'd16);
    run_to_idle(1);
    chk("t3_beats", 32'(got_q.size()), 32'd16);
    if (got_q.size() == 16) chk("t3_beat7", got_q[7], 32'd7);

    // CPU traffic on the stream's banks
    start_burst('0, 8'd8);
    run_to_idle(2);
    chk("t4_beats", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) chk("t4_beat5", got_q[5], 32'd5);

    // Wrap at end of buffer, ignored start while busy
    cpu_write(32'(MEM_DEPTH - 8), 32'hA0, 4'hF);
    cpu_write(32'(MEM_DEPTH - 4), 32'hA1, 4'hF);
    cpu_idle();
    start_burst(AW'(MEM_DEPTH - 8), 8'd4);
    i_strm_start = 1; i_strm_base = AW'(32'h100); i_strm_len = 8'd5;
    @(posedge clk); #1;
    i_strm_start = 0;
    run_to_idle(0);
    chk("t5_beats", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("t5_w0", got_q[0], 32'hA0);
      chk("t5_w1", got_q[1], 32'hA1);
      chk("t5_w2", got_q[2], 32'd0);
      chk("t5_w3", got_q[3], 32'd1);
    end
    d0 = done_cnt;
    start_burst('0, 8'd0);
    run_to_idle(0);
    chk("t5_len0_beats", 32'(got_q.size()), 32'd0);
    chk("t5_len0_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-burst
    d0 = done_cnt;
    start_burst('0, 8'd10);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (got_q.size() >= 3) break;
    end
    #2 rst_n = 0;
    #1;
    chk("t6_busy", 32'(o_strm_busy), 32'd0);
    chk("t6_valid", 32'(o_strm_valid), 32'd0);
    chk("t6_last", 32'(o_strm_last), 32'd0);
    chk("t6_data", o_strm_data, 32'd0);
    chk("t6_done", 32'(o_strm_done), 32'd0);
    chk("t6_rd_valid", 32'(o_buf_rd_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1;
    repeat (5) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    preload(16);
    d0 = done_cnt;
    start_burst('0, 8'd4);
    run_to_idle(0);
    chk("t6_after_beats", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) chk("t6_after_w3", got_q[3], 32'd3);
    chk("t6_after_done", 32'(done_cnt - d0), 32'd1);
    chk("exp_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
